// File: rtl/tri_raster_seq.sv
// tri_raster_seq: bounding-box scan triangle rasterizer sharing one edge-function unit over 3 cycles per pixel.
// Define TRI_BOTHWIND_EN to also cover clockwise triangles (all three edge values <= 0).
module tri_raster_seq #(
    parameter int CW = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tri_valid,
    output logic            tri_ready,
    input  logic [CW-1:0]   ptAX,
    input  logic [CW-1:0]   ptAY,
    input  logic [CW-1:0]   ptBX,
    input  logic [CW-1:0]   ptBY,
    input  logic [CW-1:0]   pt3X,
    input  logic [CW-1:0]   pt3Y,
    output logic            pix_valid,
    input  logic            pix_ready,
    output logic [CW-1:0]   pix_x,
    output logic [CW-1:0]   pix_y,
    output logic            done,
    output logic [2*CW:0]   pix_count
);
    typedef enum logic [2:0] {IDLE, SETUP, EVAL0, EVAL1, EVAL2, EMIT, DONE} state_t;
    state_t state_q, state_d;
    // vertex store: [0]=Ax [1]=Ay [2]=Bx [3]=By [4]=Cx [5]=Cy
    logic [5:0][CW-1:0] vtx_q, vtx_d;
    logic [CW-1:0] xmin_q, xmin_d, xmax_q, xmax_d, ymin_q, ymin_d, ymax_q, ymax_d;
    logic [CW-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic [2*CW:0] cnt_q, cnt_d;
    logic any_neg_q, any_neg_d, any_neg_now;
    logic [CW-1:0] px, py, qx, qy;
    logic signed [CW:0] dtx, dty, dpx, dpy;
    logic signed [2*CW+1:0] prod0, prod1;
    logic signed [2*CW+2:0] e;
    logic covered, adv;
`ifdef TRI_BOTHWIND_EN
    logic any_pos_q, any_pos_d, any_pos_now;
`endif

    function automatic logic [CW-1:0] min3(input logic [CW-1:0] a, b, c);
        logic [CW-1:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic logic [CW-1:0] max3(input logic [CW-1:0] a, b, c);
        logic [CW-1:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    always_comb begin
        px = (state_q == EVAL0) ? vtx_q[0] : (state_q == EVAL1) ? vtx_q[2] : vtx_q[4];
        py = (state_q == EVAL0) ? vtx_q[1] : (state_q == EVAL1) ? vtx_q[3] : vtx_q[5];
        qx = (state_q == EVAL0) ? vtx_q[2] : (state_q == EVAL1) ? vtx_q[4] : vtx_q[0];
        qy = (state_q == EVAL0) ? vtx_q[3] : (state_q == EVAL1) ? vtx_q[5] : vtx_q[1];
        dtx = $signed({1'b0, cur_x_q}) - $signed({1'b0, qx});
        dty = $signed({1'b0, cur_y_q}) - $signed({1'b0, qy});
        dpx = $signed({1'b0, px}) - $signed({1'b0, qx});
        dpy = $signed({1'b0, py}) - $signed({1'b0, qy});
        prod0 = (2*CW+2)'(dtx) * (2*CW+2)'(dpy);
        prod1 = (2*CW+2)'(dpx) * (2*CW+2)'(dty);
        e = (2*CW+3)'(prod0) - (2*CW+3)'(prod1);
        any_neg_now = e[2*CW+2] | (any_neg_q & (state_q != EVAL0));
`ifdef TRI_BOTHWIND_EN
        any_pos_now = (!e[2*CW+2] && e != '0) | (any_pos_q & (state_q != EVAL0));
        covered = !any_neg_now || !any_pos_now;
`else
        covered = !any_neg_now;
`endif
    end

    always_comb begin
        state_d = state_q;
        vtx_d = vtx_q;
        xmin_d = xmin_q;
        xmax_d = xmax_q;
        ymin_d = ymin_q;
        ymax_d = ymax_q;
        cur_x_d = cur_x_q;
        cur_y_d = cur_y_q;
        cnt_d = cnt_q;
        any_neg_d = any_neg_q;
`ifdef TRI_BOTHWIND_EN
        any_pos_d = any_pos_q;
`endif
        adv = 1'b0;
        if (state_q inside {EVAL0, EVAL1, EVAL2}) begin
            any_neg_d = any_neg_now;
`ifdef TRI_BOTHWIND_EN
            any_pos_d = any_pos_now;
`endif
        end
        case (state_q)
            IDLE: if (tri_valid) begin
                vtx_d = {pt3Y, pt3X, ptBY, ptBX, ptAY, ptAX};
                cnt_d = '0;
                state_d = SETUP;
            end
            SETUP: begin
                xmin_d = min3(vtx_q[0], vtx_q[2], vtx_q[4]);
                xmax_d = max3(vtx_q[0], vtx_q[2], vtx_q[4]);
                ymin_d = min3(vtx_q[1], vtx_q[3], vtx_q[5]);
                ymax_d = max3(vtx_q[1], vtx_q[3], vtx_q[5]);
                cur_x_d = xmin_d;
                cur_y_d = ymin_d;
                state_d = EVAL0;
            end
            EVAL0: state_d = EVAL1;
            EVAL1: state_d = EVAL2;
            EVAL2: begin
                state_d = EMIT;
                adv = !covered;
            end
            EMIT: if (pix_ready) begin
                cnt_d = cnt_q + (2*CW+1)'(1);
                adv = 1'b1;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // compare before increment so a bbox edge at the coordinate maximum never wraps
        if (adv) begin
            if (cur_x_q < xmax_q) begin
                cur_x_d = cur_x_q + CW'(1);
                state_d = EVAL0;
            end else if (cur_y_q < ymax_q) begin
                cur_x_d = xmin_q;
                cur_y_d = cur_y_q + CW'(1);
                state_d = EVAL0;
            end else begin
                state_d = DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vtx_q <= '0;
            xmin_q <= '0;
            xmax_q <= '0;
            ymin_q <= '0;
            ymax_q <= '0;
            cur_x_q <= '0;
            cur_y_q <= '0;
            cnt_q <= '0;
            any_neg_q <= 1'b0;
`ifdef TRI_BOTHWIND_EN
            any_pos_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            vtx_q <= vtx_d;
            xmin_q <= xmin_d;
            xmax_q <= xmax_d;
            ymin_q <= ymin_d;
            ymax_q <= ymax_d;
            cur_x_q <= cur_x_d;
            cur_y_q <= cur_y_d;
            cnt_q <= cnt_d;
            any_neg_q <= any_neg_d;
`ifdef TRI_BOTHWIND_EN
            any_pos_q <= any_pos_d;
`endif
        end
    end

    assign tri_ready = (state_q == IDLE);
    assign pix_valid = (state_q == EMIT);
    assign done = (state_q == DONE);
    assign pix_x = cur_x_q;
    assign pix_y = cur_y_q;
    assign pix_count = cnt_q;
endmodule

// File: tb/tb_tri_raster_seq.sv
// tb_tri_raster_seq: directed and random triangles checked against an arithmetic coverage model.
module tb_tri_raster_seq;
    localparam int CW = 12;
    logic clk = 1'b0, rst = 1'b1, tri_valid = 1'b0, pix_ready = 1'b0;
    logic [CW-1:0] ptAX = '0, ptAY = '0, ptBX = '0, ptBY = '0, pt3X = '0, pt3Y = '0;
    logic tri_ready, pix_valid, done;
    logic [CW-1:0] pix_x, pix_y;
    logic [2*CW:0] pix_count;
    int checks = 0, errors = 0;

    typedef struct {int x; int y;} pt_t;
    pt_t expq[$];

    tri_raster_seq #(.CW(CW)) dut (
        .clk(clk), .rst(rst), .tri_valid(tri_valid), .tri_ready(tri_ready),
        .ptAX(ptAX), .ptAY(ptAY), .ptBX(ptBX), .ptBY(ptBY), .pt3X(pt3X), .pt3Y(pt3Y),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
        .done(done), .pix_count(pix_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint ef(longint px, py, qx, qy, tx, ty);
        return (tx - qx) * (py - qy) - (px - qx) * (ty - qy);
    endfunction

    // expected pixel stream: every bbox point, row-major, whose edge values satisfy the winding rule
    task automatic build_model(input int ax, ay, bx, by, cx, cy);
        longint e0, e1, e2;
        bit inside_pt;
        int x0, x1, y0, y1;
        expq.delete();
        x0 = ax < bx ? ax : bx; x0 = x0 < cx ? x0 : cx;
        x1 = ax > bx ? ax : bx; x1 = x1 > cx ? x1 : cx;
        y0 = ay < by ? ay : by; y0 = y0 < cy ? y0 : cy;
        y1 = ay > by ? ay : by; y1 = y1 > cy ? y1 : cy;
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++) begin
                e0 = ef(ax, ay, bx, by, x, y);
                e1 = ef(bx, by, cx, cy, x, y);
                e2 = ef(cx, cy, ax, ay, x, y);
                inside_pt = (e0 >= 0 && e1 >= 0 && e2 >= 0);
`ifdef TRI_BOTHWIND_EN
                inside_pt = inside_pt || (e0 <= 0 && e1 <= 0 && e2 <= 0);
`endif
                if (inside_pt) expq.push_back('{x, y});
            end
    endtask

    // mode 0: pix_ready high; 1: random pix_ready; 2: stall 2nd pixel 5 cycles and poke tri_valid mid-scan
    task automatic run_tri(input int ax, ay, bx, by, cx, cy, input int mode, input int exp_n, input int exp_lat);
        int cyc, idx, done_cnt, stall, first_lat, hx, hy;
        bit hold_v;
        build_model(ax, ay, bx, by, cx, cy);
        @(negedge clk);
        chk("tri_ready before accept", tri_ready, 1);
        ptAX = ax[CW-1:0]; ptAY = ay[CW-1:0];
        ptBX = bx[CW-1:0]; ptBY = by[CW-1:0];
        pt3X = cx[CW-1:0]; pt3Y = cy[CW-1:0];
        tri_valid = 1'b1;
        pix_ready = 1'b1;
        @(negedge clk);
        tri_valid = (mode == 2);
        cyc = 1; idx = 0; done_cnt = 0; stall = 0; first_lat = -1; hold_v = 0; hx = 0; hy = 0;
        while (done_cnt == 0 && cyc < 20000) begin
            if (hold_v) begin
                chk("held pix_valid", pix_valid, 1);
                chk("held pix_x", pix_x, hx);
                chk("held pix_y", pix_y, hy);
            end
            if (mode == 2) chk("tri_ready during scan", tri_ready, 0);
            if (pix_valid && first_lat < 0) first_lat = cyc;
            pix_ready = (mode == 1) ? 1'($urandom_range(0, 1)) :
                        (mode == 2 && idx == 1 && pix_valid && stall < 5) ? 1'b0 : 1'b1;
            if (mode == 2 && !pix_ready && pix_valid) stall++;
            hold_v = pix_valid && !pix_ready;
            hx = pix_x; hy = pix_y;
            if (pix_valid && pix_ready) begin
                if (idx < expq.size()) begin
                    chk("pixel x", pix_x, expq[idx].x);
                    chk("pixel y", pix_y, expq[idx].y);
                end else chk("extra pixel index", idx, expq.size());
                idx++;
            end
            if (done) begin
                done_cnt++;
                chk("pix_count at done", pix_count, expq.size());
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        tri_valid = 1'b0;
        chk("done seen (timeout if 0)", done_cnt, 1);
        chk("pixels emitted", idx, expq.size());
        if (exp_n >= 0) chk("directed pixel count", idx, exp_n);
        if (exp_lat > 0) chk("first pix_valid latency", first_lat, exp_lat);
        if (mode == 2) chk("stall cycles applied", stall, 5);
        @(negedge clk);
        chk("done single pulse", done, 0);
        chk("tri_ready after done", tri_ready, 1);
        chk("pix_count stable after done", pix_count, expq.size());
    endtask

    initial begin
        int got, bad, base, rx[6];
        repeat (3) @(negedge clk);
        chk("reset tri_ready", tri_ready, 1);
        chk("reset pix_valid", pix_valid, 0);
        chk("reset done", done, 0);
        chk("reset pix_x", pix_x, 0);
        chk("reset pix_y", pix_y, 0);
        chk("reset pix_count", pix_count, 0);
        rst = 1'b0;

        run_tri(0, 0, 2, 0, 0, 2, 0, 6, 5);
        run_tri(10, 10, 30, 10, 20, 30, 0, -1, 5);
        run_tri(5, 5, 5, 5, 5, 5, 0, 1, 5);
`ifdef TRI_BOTHWIND_EN
        run_tri(0, 0, 0, 2, 2, 0, 0, 6, 5);
`else
        run_tri(0, 0, 0, 2, 2, 0, 0, -1, 0);
`endif
        run_tri(0, 0, 2, 0, 0, 2, 2, 6, 0);
        run_tri(4095, 4090, 4085, 4095, 4095, 4095, 1, -1, 0);

        // abort during EVAL1 of the third pixel
        @(negedge clk);
        ptAX = 0; ptAY = 0; ptBX = 2; ptBY = 0; pt3X = 0; pt3Y = 2;
        tri_valid = 1'b1; pix_ready = 1'b1;
        @(negedge clk);
        tri_valid = 1'b0;
        got = 0;
        for (int c = 1; c < 11; c++) begin
            if (pix_valid) got++;
            @(negedge clk);
        end
        chk("pixels before abort", got, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort pix_valid", pix_valid, 0);
        chk("abort done", done, 0);
        chk("abort tri_ready", tri_ready, 1);
        chk("abort pix_count", pix_count, 0);
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (pix_valid || done || !tri_ready) bad++;
        end
        chk("quiet after abort", bad, 0);
        run_tri(0, 0, 2, 0, 0, 2, 0, 6, 5);

        for (int t = 0; t < 16; t++) begin
            base = (t % 3 == 0) ? 4085 : $urandom_range(0, 4000);
            foreach (rx[k]) rx[k] = base + $urandom_range(0, 10);
            run_tri(rx[0], rx[1], rx[2], rx[3], rx[4], rx[5], t % 2, -1, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
